tea_sched: RTL



---
 rtl/tea_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tea_sched.sv
// tea_sched: two-requester round-robin scheduler in front of a fixed-latency tea core.
// Drains the core before any mode change and returns tagged results through a credit-checked FIFO.
module tea_sched #(
  parameter int NUM_STAGES = 4,
  parameter int RSP_DEPTH  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [1:0]       i_req_mode,
  input  logic [1:0][31:0] i_req_data,
  input  logic [1:0][63:0] i_req_key,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_data,
  output logic             o_rsp_id,
  output logic             o_rsp_mode,
  output logic             o_busy,
  output logic             o_tea_mode,
  output logic [31:0]      o_tea_input_data,
  output logic [63:0]      o_tea_encryption_key,
  input  logic [31:0]      i_tea_output_data
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + NUM_STAGES + 1);

  typedef enum logic [1:0] {SETTLE, RUN, DRAIN, SWITCH} StateT;

  StateT r_state;
  StateT w_stateNext;

  logic r_curMode;
  logic r_rrPtr;
  logic r_lock;
  logic r_lockId;

  logic [NUM_STAGES-1:0] r_tagValid;
  logic [NUM_STAGES-1:0] r_tagId;
  logic [NUM_STAGES-1:0] r_tagMode;

  logic [33:0]      r_fifoMem [RSP_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_fifoCount;

  logic [CNT_W-1:0] w_inflightCount;
  logic             w_credit;
  logic             w_win;
  logic             w_winValid;
  logic             w_winMode;
  logic             w_inRun;
  logic             w_accept;
  logic             w_modeMiss;
  logic             w_stall;
  logic             w_push;
  logic             w_pop;
  logic             w_drained;

  always_comb begin
    w_inflightCount = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_inflightCount = w_inflightCount + CNT_W'(r_tagValid[i]);
    end
  end

  // Words already in the core count against FIFO space, so a push can never find the FIFO full.
  assign w_credit = (CNT_W'(r_fifoCount) + w_inflightCount) < CNT_W'(RSP_DEPTH);

  always_comb begin
    w_win = r_rrPtr;
    if (r_lock) begin
      w_win = r_lockId;
    end else if (!i_req_valid[r_rrPtr]) begin
      w_win = ~r_rrPtr;
    end
  end

  assign w_winValid = i_req_valid[w_win];
  assign w_winMode  = i_req_mode[w_win];
  assign w_inRun    = (r_state == RUN);
  assign w_accept   = w_inRun && w_winValid && (w_winMode == r_curMode) && w_credit;
  assign w_modeMiss = w_inRun && w_winValid && (w_winMode != r_curMode);
  assign w_stall    = w_inRun && w_winValid && (w_winMode == r_curMode) && !w_credit;
  assign w_drained  = (w_inflightCount == '0);
  assign w_push     = r_tagValid[NUM_STAGES-1];
  assign w_pop      = o_rsp_valid && i_rsp_ready;

  always_comb begin
    w_stateNext          = r_state;
    o_req_ready          = '0;
    o_tea_input_data     = '0;
    o_tea_encryption_key = '0;
    case (r_state)
      SETTLE:  w_stateNext = RUN;
      RUN:     if (w_modeMiss) w_stateNext = DRAIN;
      DRAIN:   if (w_drained) w_stateNext = SWITCH;
      SWITCH:  w_stateNext = RUN;
      default: w_stateNext = SETTLE;
    endcase
    if (w_accept) begin
      o_req_ready[w_win]   = 1'b1;
      o_tea_input_data     = i_req_data[w_win];
      o_tea_encryption_key = i_req_key[w_win];
    end
  end

  // A blocked winner stays locked so the grant is not re-arbitrated while it waits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= SETTLE;
      r_curMode <= 1'b0;
      r_rrPtr   <= 1'b0;
      r_lock    <= 1'b0;
      r_lockId  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_rrPtr <= ~w_win;
        r_lock  <= 1'b0;
      end else if (w_modeMiss || w_stall) begin
        r_lock   <= 1'b1;
        r_lockId <= w_win;
      end
      if (r_state == DRAIN && w_drained) begin
        r_curMode <= ~r_curMode;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tagValid <= '0;
      r_tagId    <= '0;
      r_tagMode  <= '0;
    end else begin
      r_tagValid[0] <= w_accept;
      r_tagId[0]    <= w_win;
      r_tagMode[0]  <= r_curMode;
      for (int i = 1; i < NUM_STAGES; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagId[i]    <= r_tagId[i-1];
        r_tagMode[i]  <= r_tagMode[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= {i_tea_output_data, r_tagId[NUM_STAGES-1], r_tagMode[NUM_STAGES-1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_fifoCount <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_fifoCount <= r_fifoCount + (PTR_W+1)'(1);
      end else if (!w_push && w_pop) begin
        r_fifoCount <= r_fifoCount - (PTR_W+1)'(1);
      end
    end
  end

  assign o_rsp_valid = (r_fifoCount != '0);
  assign {o_rsp_data, o_rsp_id, o_rsp_mode} = r_fifoMem[r_rdPtr];
  assign o_busy      = !w_drained || (r_fifoCount != '0) || (r_state != RUN);
  assign o_tea_mode  = r_curMode;

endmodule
